// File: rtl/dice_pkg.sv
// rtl/dice_pkg.sv - shared constants for the dice roller and its display decoders
// Contents: FSM state encodings, blank face code, 7-segment patterns {g,f,e,d,c,b,a},
//           and the face-acceptance helper used by the framer.
package dice_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ROLL   = 2'd1;
    localparam logic [1:0] ST_SETTLE = 2'd2;
    localparam logic [1:0] ST_SHOW   = 2'd3;

    localparam logic [2:0] FACE_BLANK = 3'd0;
    localparam logic [2:0] FACE_ONE   = 3'd1;

    localparam logic [6:0] SEG_1   = 7'b0000110;
    localparam logic [6:0] SEG_2   = 7'b1011011;
    localparam logic [6:0] SEG_3   = 7'b1001111;
    localparam logic [6:0] SEG_4   = 7'b1100110;
    localparam logic [6:0] SEG_5   = 7'b1101101;
    localparam logic [6:0] SEG_6   = 7'b1111101;
    localparam logic [6:0] SEG_OFF = 7'b0000000;

    // 0 and 7 are discarded so the six remaining codes stay equiprobable.
    function automatic logic is_face(input logic [2:0] cand);
        return (cand != 3'd0) && (cand != 3'd7);
    endfunction

endpackage

// File: rtl/dice_roller_if.sv
// rtl/dice_roller_if.sv - signal bundle between the dice roller and its environment
// Signals: bit_in (serial random bit), roll (raw button), face, seg, valid, busy, fallback.
// Modports: master drives bit_in/roll and observes results; slave is the dice roller side.
interface dice_roller_if;

    logic       bit_in;
    logic       roll;
    logic [2:0] face;
    logic [6:0] seg;
    logic       valid;
    logic       busy;
    logic       fallback;

    modport master (
        output bit_in,
        output roll,
        input  face,
        input  seg,
        input  valid,
        input  busy,
        input  fallback
    );

    modport slave (
        input  bit_in,
        input  roll,
        output face,
        output seg,
        output valid,
        output busy,
        output fallback
    );

endinterface

// File: rtl/seg7_dec.sv
// rtl/seg7_dec.sv - combinational face-to-7-segment decoder
// Ports: face [2:0] in (1..6 shown, anything else blank), seg [6:0] out {g,f,e,d,c,b,a} active-high.
module seg7_dec
    import dice_pkg::*;
(
    input  logic [2:0] face,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (face)
            3'd1:    seg = SEG_1;
            3'd2:    seg = SEG_2;
            3'd3:    seg = SEG_3;
            3'd4:    seg = SEG_4;
            3'd5:    seg = SEG_5;
            3'd6:    seg = SEG_6;
            default: seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/dice_roller.sv
// rtl/dice_roller.sv - frames a random bit stream into fair die faces and runs the roll FSM
// Ports: Cp clock (rising edge), Rn async active-low reset,
//        io.slave: bit_in, roll in; face, seg, valid, busy, fallback out.
// Parameters: SPIN_DIV - display updates every 2**SPIN_DIV accepted candidates while rolling;
//             MAX_REJECT - consecutive rejects after release before face 1 is forced.
module dice_roller
    import dice_pkg::*;
#(
    parameter int SPIN_DIV   = 2,
    parameter int MAX_REJECT = 8
) (
    input  logic          Cp,
    input  logic          Rn,
    dice_roller_if.slave  io
);

    localparam int SPIN_W = (SPIN_DIV > 0) ? SPIN_DIV : 1;
    localparam int REJ_W  = (MAX_REJECT > 1) ? $clog2(MAX_REJECT) : 1;
    localparam logic [REJ_W-1:0]  REJ_LAST  = REJ_W'(MAX_REJECT - 1);
    localparam logic [SPIN_W-1:0] SPIN_LAST = SPIN_W'((1 << SPIN_DIV) - 1);

    logic              roll_s1, roll_s2, roll_d;
    logic [1:0]        sh;
    logic [1:0]        bitcnt;
    logic [1:0]        state;
    logic [2:0]        face;
    logic              fallback;
    logic [SPIN_W-1:0] spin;
    logic [REJ_W-1:0]  rej;

    logic       rise, fall;
    logic       frame_end;
    logic [2:0] cand;
    logic       cand_ok, cand_rej;
    logic       spin_last;

    // Edges are taken from the synchronized value, never from the raw pin.
    assign rise = roll_s2 & ~roll_d;
    assign fall = ~roll_s2 & roll_d;

    // The bit arriving on the third edge of a frame is the LSB of the candidate.
    assign frame_end = (bitcnt == 2'd2);
    assign cand      = {sh, io.bit_in};
    assign cand_ok   = frame_end & is_face(cand);
    assign cand_rej  = frame_end & ~is_face(cand);
    assign spin_last = (SPIN_DIV == 0) ? 1'b1 : (spin == SPIN_LAST);

    always_ff @(posedge Cp or negedge Rn) begin
        if (!Rn) begin
            roll_s1  <= 1'b0;
            roll_s2  <= 1'b0;
            roll_d   <= 1'b0;
            sh       <= 2'b00;
            bitcnt   <= 2'd0;
            state    <= ST_IDLE;
            face     <= FACE_BLANK;
            fallback <= 1'b0;
            spin     <= '0;
            rej      <= '0;
        end else begin
            roll_s1 <= io.roll;
            roll_s2 <= roll_s1;
            roll_d  <= roll_s2;

            sh     <= {sh[0], io.bit_in};
            bitcnt <= frame_end ? 2'd0 : bitcnt + 2'd1;

            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        state <= ST_ROLL;
                        spin  <= '0;
                    end
                end
                ST_ROLL: begin
                    // A candidate landing with the release only spins the display;
                    // the final face comes from a later frame.
                    if (cand_ok) begin
                        spin <= spin + 1'b1;
                        if (spin_last) begin
                            face <= cand;
                        end
                    end
                    if (fall) begin
                        state <= ST_SETTLE;
                        rej   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (rise) begin
                        state <= ST_ROLL;
                        spin  <= '0;
                    end else if (cand_ok) begin
                        face  <= cand;
                        state <= ST_SHOW;
                    end else if (cand_rej) begin
                        if (rej == REJ_LAST) begin
                            face     <= FACE_ONE;
                            fallback <= 1'b1;
                            state    <= ST_SHOW;
                        end else begin
                            rej <= rej + 1'b1;
                        end
                    end
                end
                default: begin
                    if (rise) begin
                        state    <= ST_ROLL;
                        spin     <= '0;
                        fallback <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign io.face     = face;
    assign io.fallback = fallback;
    assign io.valid    = (state == ST_SHOW);
    assign io.busy     = (state == ST_ROLL) || (state == ST_SETTLE);

    seg7_dec u_seg7_dec (
        .face (face),
        .seg  (io.seg)
    );

endmodule
